// File: rtl/kw_arb_requester_pkg.sv
// Shared types and default parameters for the arbiter requester front end.
// The optional starvation monitor is enabled with `define KW_ARB_REQ_STARVE_EN.
package kw_arb_requester_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        BURST = 2'd2
    } kw_arb_req_state_t;

    localparam int unsigned KW_ARB_REQ_N_DEF             = 16;
    localparam int unsigned KW_ARB_REQ_LEN_W_DEF         = 4;
    localparam int unsigned KW_ARB_REQ_STARVE_CYCLES_DEF = 64;

endpackage

// File: rtl/kw_arb_requester_chan.sv
// One requester channel: command latch, request/lock FSM and beat pacing.
// The starvation counter exists only when KW_ARB_REQ_STARVE_EN is defined.
module kw_arb_requester_chan
    import kw_arb_requester_pkg::*;
#(
    parameter int unsigned LEN_W         = KW_ARB_REQ_LEN_W_DEF,
    parameter int unsigned STARVE_CYCLES = KW_ARB_REQ_STARVE_CYCLES_DEF
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             cmd_valid,
    input  logic [LEN_W-1:0] cmd_len,
    output logic             cmd_ready,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             data_last,
    output logic             request,
    output logic             lock,
    input  logic             grant,
    output logic             busy,
    output logic             starved
);

    kw_arb_req_state_t state_q, state_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              request_q, request_d;
    logic              lock_q, lock_d;
    logic              busy_q, busy_d;
    logic              beat;

    assign data_ready = (state_q != IDLE) && grant;
    assign data_last  = (state_q != IDLE) && (cnt_q == '0);
    assign beat       = data_valid && data_ready;

    // Registered outputs decode the next state so they line up with state_q.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    cnt_d   = cmd_len;
                    state_d = REQ;
                end
            end
            REQ, BURST: begin
                if (beat) begin
                    if (cnt_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d   = cnt_q - LEN_W'(1);
                        state_d = BURST;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        cmd_ready_d = (state_d == IDLE);
        request_d   = (state_d != IDLE);
        lock_d      = (state_d == BURST);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cmd_ready_q <= 1'b1;
            request_q   <= 1'b0;
            lock_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cmd_ready_q <= cmd_ready_d;
            request_q   <= request_d;
            lock_q      <= lock_d;
            busy_q      <= busy_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign request   = request_q;
    assign lock      = lock_q;
    assign busy      = busy_q;

`ifdef KW_ARB_REQ_STARVE_EN
    localparam int unsigned       SC_W   = $clog2(STARVE_CYCLES + 1);
    localparam logic [SC_W-1:0]   SC_MAX = SC_W'(STARVE_CYCLES);

    logic [SC_W-1:0] starve_cnt_q, starve_cnt_d;
    logic            starved_q, starved_d;

    // Counts only ungranted REQ cycles; any grant or leaving REQ restarts it.
    always_comb begin
        starve_cnt_d = '0;
        if (state_q == REQ && !grant) begin
            starve_cnt_d = (starve_cnt_q == SC_MAX) ? starve_cnt_q : starve_cnt_q + SC_W'(1);
        end
        starved_d = starved_q;
        if (grant || state_d == IDLE) begin
            starved_d = 1'b0;
        end else if (starve_cnt_d == SC_MAX) begin
            starved_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            starve_cnt_q <= '0;
            starved_q    <= 1'b0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            starved_q    <= starved_d;
        end
    end

    assign starved = starved_q;
`else
    logic starve_unused;
    assign starve_unused = (STARVE_CYCLES == 0);
    assign starved       = 1'b0;
`endif

endmodule

// File: rtl/kw_arb_requester.sv
// N-channel requester front end for the static-priority arbiter.
// Define KW_ARB_REQ_STARVE_EN to build the per-channel starvation monitors.
module kw_arb_requester
    import kw_arb_requester_pkg::*;
#(
    parameter int unsigned N             = KW_ARB_REQ_N_DEF,
    parameter int unsigned LEN_W         = KW_ARB_REQ_LEN_W_DEF,
    parameter int unsigned STARVE_CYCLES = KW_ARB_REQ_STARVE_CYCLES_DEF
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [N-1:0]       cmd_valid,
    input  logic [N*LEN_W-1:0] cmd_len,
    output logic [N-1:0]       cmd_ready,
    input  logic [N-1:0]       data_valid,
    output logic [N-1:0]       data_ready,
    output logic [N-1:0]       data_last,
    output logic [N-1:0]       request,
    output logic [N-1:0]       lock,
    input  logic [N-1:0]       grant,
    output logic [N-1:0]       busy,
    output logic [N-1:0]       starved
);

    for (genvar i = 0; i < N; i++) begin : g_chan
        kw_arb_requester_chan #(
            .LEN_W         (LEN_W),
            .STARVE_CYCLES (STARVE_CYCLES)
        ) u_chan (
            .clock      (clock),
            .reset_n    (reset_n),
            .cmd_valid  (cmd_valid[i]),
            .cmd_len    (cmd_len[i*LEN_W +: LEN_W]),
            .cmd_ready  (cmd_ready[i]),
            .data_valid (data_valid[i]),
            .data_ready (data_ready[i]),
            .data_last  (data_last[i]),
            .request    (request[i]),
            .lock       (lock[i]),
            .grant      (grant[i]),
            .busy       (busy[i]),
            .starved    (starved[i])
        );
    end

endmodule

// File: tb/tb_kw_arb_requester.sv
// Directed bench for kw_arb_requester: a beat-counting channel model checked every
// cycle, plus literal expectations per scenario (KW_ARB_REQ_STARVE_EN aware).
module tb_kw_arb_requester;

    localparam int N     = 16;
    localparam int LEN_W = 4;
    localparam int SC    = 64;
`ifdef KW_ARB_REQ_STARVE_EN
    localparam bit STARVE_ON = 1'b1;
`else
    localparam bit STARVE_ON = 1'b0;
`endif

    logic               clock = 1'b0;
    logic               reset_n;
    logic [N-1:0]       cmd_valid, data_valid, grant;
    logic [N*LEN_W-1:0] cmd_len;
    logic [N-1:0]       cmd_ready, data_ready, data_last, request, lock, busy, starved;

    always #5 clock = ~clock;

    kw_arb_requester #(
        .N             (N),
        .LEN_W         (LEN_W),
        .STARVE_CYCLES (SC)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .cmd_valid  (cmd_valid),
        .cmd_len    (cmd_len),
        .cmd_ready  (cmd_ready),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .data_last  (data_last),
        .request    (request),
        .lock       (lock),
        .grant      (grant),
        .busy       (busy),
        .starved    (starved)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: beats still owed and beats already moved per channel.
    int rem   [N];
    int done  [N];
    int wait_c[N];
    bit starv [N];

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N; i++) begin
                rem[i] = 0; done[i] = 0; wait_c[i] = 0; starv[i] = 1'b0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (rem[i] == 0) begin
                    if (cmd_valid[i]) begin
                        rem[i]  = int'(cmd_len[i*LEN_W +: LEN_W]) + 1;
                        done[i] = 0;
                    end
                end else begin
                    if (grant[i]) begin
                        wait_c[i] = 0; starv[i] = 1'b0;
                    end else if (done[i] == 0) begin
                        wait_c[i]++;
                        if (wait_c[i] >= SC) starv[i] = 1'b1;
                    end else begin
                        wait_c[i] = 0;
                    end
                    if (grant[i] && data_valid[i]) begin
                        rem[i]--; done[i]++;
                    end
                    if (rem[i] == 0) begin
                        wait_c[i] = 0; starv[i] = 1'b0;
                    end
                end
            end
        end
    end

    always @(negedge clock) begin : compare
        logic [N-1:0] e_rdy, e_req, e_lock, e_busy, e_dr, e_dl, e_st;
        for (int i = 0; i < N; i++) begin
            e_busy[i] = (rem[i] != 0);
            e_rdy[i]  = (rem[i] == 0);
            e_req[i]  = (rem[i] != 0);
            e_lock[i] = (rem[i] != 0) && (done[i] > 0);
            e_dr[i]   = (rem[i] != 0) && grant[i];
            e_dl[i]   = (rem[i] == 1);
            e_st[i]   = STARVE_ON && starv[i];
        end
        check("cmp_cmd_ready",  cmd_ready,  e_rdy);
        check("cmp_request",    request,    e_req);
        check("cmp_lock",       lock,       e_lock);
        check("cmp_busy",       busy,       e_busy);
        check("cmp_data_ready", data_ready, e_dr);
        check("cmp_data_last",  data_last,  e_dl);
        check("cmp_starved",    starved,    e_st);
    end

    // Observed activity, used by the scenario-level literal checks.
    int beats[N];
    int lasts[N];
    int lockc[N];
    int drc  [N];

    always @(negedge clock) begin
        for (int i = 0; i < N; i++) begin
            if (data_valid[i] && data_ready[i]) beats[i]++;
            if (data_valid[i] && data_ready[i] && data_last[i]) lasts[i]++;
            if (lock[i]) lockc[i]++;
            if (data_ready[i]) drc[i]++;
        end
    end

    task automatic clr_stats();
        for (int i = 0; i < N; i++) begin
            beats[i] = 0; lasts[i] = 0; lockc[i] = 0; drc[i] = 0;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic set_len(input int ch, input int len);
        cmd_len[ch*LEN_W +: LEN_W] = LEN_W'(len);
    endtask

    initial begin
        reset_n    = 1'b0;
        cmd_valid  = '0;
        cmd_len    = '0;
        data_valid = '0;
        grant      = '0;
        clr_stats();
        tick(2);
        check("rst_cmd_ready", cmd_ready, 64'hFFFF);
        check("rst_request",   request,   64'h0);
        check("rst_lock",      lock,      64'h0);
        check("rst_data_last", data_last, 64'h0);
        reset_n = 1'b1;
        tick(1);

        // Single beat on channel 3
        clr_stats();
        set_len(3, 0); grant[3] = 1'b1; data_valid[3] = 1'b1; cmd_valid[3] = 1'b1;
        tick(1);
        cmd_valid[3] = 1'b0;
        #1;
        check("t1_request",    request[3],    1);
        check("t1_data_ready", data_ready[3], 1);
        check("t1_data_last",  data_last[3],  1);
        check("t1_lock",       lock[3],       0);
        tick(1);
        #1;
        check("t1_cmd_ready_back", cmd_ready[3], 1);
        check("t1_beats",          beats[3],     1);
        check("t1_lock_cycles",    lockc[3],     0);
        grant[3] = 1'b0; data_valid[3] = 1'b0;
        tick(1);

        // Maximum burst on channel 1
        clr_stats();
        set_len(1, 15); grant[1] = 1'b1; data_valid[1] = 1'b1; cmd_valid[1] = 1'b1;
        tick(1);
        cmd_valid[1] = 1'b0;
        #1;
        check("t2_lock_first", lock[1], 0);
        tick(15);
        #1;
        check("t2_last_on_16", data_last[1], 1);
        check("t2_lock_on_16", lock[1],      1);
        tick(1);
        #1;
        check("t2_lock_fell",   lock[1],      0);
        check("t2_cmd_ready",   cmd_ready[1], 1);
        check("t2_beats",       beats[1],     16);
        check("t2_last_count",  lasts[1],     1);
        check("t2_lock_cycles", lockc[1],     15);
        grant[1] = 1'b0; data_valid[1] = 1'b0;
        tick(1);

        // Grant drop after beat 2 on channel 2
        clr_stats();
        set_len(2, 3); grant[2] = 1'b1; data_valid[2] = 1'b1; cmd_valid[2] = 1'b1;
        tick(1);
        cmd_valid[2] = 1'b0;
        tick(2);
        grant[2] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("t3_gap_data_ready", data_ready[2], 0);
            check("t3_gap_lock",       lock[2],       1);
            tick(1);
        end
        check("t3_beats_in_gap", beats[2], 2);
        grant[2] = 1'b1;
        tick(2);
        #1;
        check("t3_beats",   beats[2], 4);
        check("t3_busy",    busy[2],  0);
        check("t3_lasts",   lasts[2], 1);
        grant[2] = 1'b0; data_valid[2] = 1'b0;
        tick(1);

        // Channels 0 and 5 share an alternating grant; channel 7 gets a stray grant
        clr_stats();
        set_len(0, 2); set_len(5, 4);
        data_valid[0] = 1'b1; data_valid[5] = 1'b1; data_valid[7] = 1'b1;
        cmd_valid[0] = 1'b1; cmd_valid[5] = 1'b1;
        grant[7] = 1'b1;
        tick(1);
        cmd_valid[0] = 1'b0; cmd_valid[5] = 1'b0;
        for (int k = 0; k < 12; k++) begin
            grant[0] = (k % 2 == 1);
            grant[5] = (k % 2 == 0);
            tick(1);
        end
        #1;
        check("t4_beats_ch0",   beats[0], 3);
        check("t4_beats_ch5",   beats[5], 5);
        check("t4_dr_ch7",      drc[7],   0);
        check("t4_idle_ch0_5",  {busy[5], busy[0]}, 0);
        grant = '0; data_valid = '0;
        tick(1);

        // Reset during beat 2 of 4 on channel 4
        clr_stats();
        set_len(4, 3); grant[4] = 1'b1; data_valid[4] = 1'b1; cmd_valid[4] = 1'b1;
        tick(1);
        cmd_valid[4] = 1'b0;
        tick(1);
        #2;
        reset_n = 1'b0;
        #1;
        check("t5_async_request",    request,    64'h0);
        check("t5_async_lock",       lock,       64'h0);
        check("t5_async_data_ready", data_ready, 64'h0);
        check("t5_async_cmd_ready",  cmd_ready,  64'hFFFF);
        check("t5_async_busy",       busy,       64'h0);
        tick(1);
        reset_n = 1'b1;
        clr_stats();
        set_len(4, 1); cmd_valid[4] = 1'b1;
        tick(1);
        cmd_valid[4] = 1'b0;
        tick(2);
        #1;
        check("t5_new_beats", beats[4], 2);
        check("t5_new_idle",  busy[4],  0);
        grant[4] = 1'b0; data_valid[4] = 1'b0;
        tick(1);

        // Starvation on channel 6
        clr_stats();
        set_len(6, 0); data_valid[6] = 1'b1; cmd_valid[6] = 1'b1;
        tick(1);
        cmd_valid[6] = 1'b0;
        tick(63);
        #1;
        check("t6_not_yet", starved[6], 0);
        tick(1);
        #1;
        check("t6_starved", starved[6], STARVE_ON);
        grant[6] = 1'b1;
        tick(1);
        #1;
        check("t6_cleared", starved[6], 0);
        check("t6_beats",   beats[6],   1);
        grant[6] = 1'b0; data_valid[6] = 1'b0;
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
